mem_stage: RTL and testbench

Memory-access stage of the mips32 five-stage pipeline, directly downstream of the `ex` stage. It consumes `ex`'s `o_alu_result` as the effective address and `o_forwarded_data_B` as store data. It owns the data RAM, which supports byte, halfword and word accesses with alignment checking. It also holds the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: byte/half/word data RAM with alignment checking and the MEM/WB register.
// Optional MEM_DEBUG_PORT_EN adds a combinational debug word-read port (i_dbg_addr/o_dbg_data).
module mem_stage #(
  parameter int BUS_SIZE  = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_halt,
  input  logic                i_mem_rd,
  input  logic                i_mem_wr,
  input  logic [1:0]          i_width,
  input  logic                i_sign_ext,
  input  logic [BUS_SIZE-1:0] i_alu_result,
  input  logic [BUS_SIZE-1:0] i_data_store,
  input  logic [4:0]          i_wb_addr,
  input  logic                i_mem_to_reg,
  input  logic                i_reg_write,
  output logic [BUS_SIZE-1:0] o_mem_data,
  output logic [BUS_SIZE-1:0] o_alu_result,
  output logic [4:0]          o_wb_addr,
  output logic                o_mem_to_reg,
  output logic                o_reg_write,
  output logic                o_misaligned
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_BITS-1:0] i_dbg_addr,
  output logic [BUS_SIZE-1:0]  o_dbg_data
`endif
);

  localparam int LANES = BUS_SIZE / 8;

  logic [BUS_SIZE-1:0]  ram [MEM_DEPTH];
  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic                 lane_fault;
  logic                 misaligned;
  logic                 store_en;
  logic [LANES-1:0]     wr_be;
  logic [BUS_SIZE-1:0]  wr_data;
  logic [BUS_SIZE-1:0]  rd_word;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [BUS_SIZE-1:0]  load_data;

  // Upper address bits are dropped, so the byte address wraps modulo the RAM size.
  assign word_idx = i_alu_result[ADDR_BITS+1:2];
  assign lane     = i_alu_result[1:0];

  always_comb begin
    lane_fault = 1'b0;
    case (i_width)
      2'b00:   lane_fault = 1'b0;
      2'b01:   lane_fault = lane[0];
      default: lane_fault = |lane;
    endcase
  end

  assign misaligned = (i_mem_rd | i_mem_wr) & lane_fault;
  assign store_en   = i_mem_wr & ~misaligned & ~i_halt & ~i_reset;

  always_comb begin
    wr_be   = '0;
    wr_data = i_data_store;
    case (i_width)
      2'b00: begin
        wr_be[lane] = 1'b1;
        wr_data     = {LANES{i_data_store[7:0]}};
      end
      2'b01: begin
        wr_be[{lane[1], 1'b0}] = 1'b1;
        wr_be[{lane[1], 1'b1}] = 1'b1;
        wr_data                = {(LANES/2){i_data_store[15:0]}};
      end
      default: begin
        wr_be   = '1;
        wr_data = i_data_store;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (store_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_be[l]) ram[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

  // Load path sees the pre-store contents of the word in the same cycle.
  assign rd_word = ram[word_idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    if (i_mem_rd) begin
      case (i_width)
        2'b00:   load_data = {{(BUS_SIZE-8){i_sign_ext & rd_byte[7]}}, rd_byte};
        2'b01:   load_data = {{(BUS_SIZE-16){i_sign_ext & rd_half[15]}}, rd_half};
        default: load_data = rd_word;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mem_data   <= '0;
      o_alu_result <= '0;
      o_wb_addr    <= '0;
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (!i_halt) begin
      o_mem_data   <= load_data;
      o_alu_result <= i_alu_result;
      o_wb_addr    <= i_wb_addr;
      o_mem_to_reg <= i_mem_to_reg;
      o_reg_write  <= i_reg_write & ~misaligned;
      o_misaligned <= misaligned;
    end
  end

`ifdef MEM_DEBUG_PORT_EN
  assign o_dbg_data = ram[i_dbg_addr];
`else
  // Without the debug port the RAM is reachable only through the pipeline access.
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-array style reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset, i_halt, i_mem_rd, i_mem_wr, i_sign_ext, i_mem_to_reg, i_reg_write;
  logic [1:0]  i_width;
  logic [31:0] i_alu_result, i_data_store;
  logic [4:0]  i_wb_addr;
  logic [31:0] o_mem_data, o_alu_result;
  logic [4:0]  o_wb_addr;
  logic        o_mem_to_reg, o_reg_write, o_misaligned;

  mem_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt), .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
    .i_width(i_width), .i_sign_ext(i_sign_ext), .i_alu_result(i_alu_result),
    .i_data_store(i_data_store), .i_wb_addr(i_wb_addr), .i_mem_to_reg(i_mem_to_reg),
    .i_reg_write(i_reg_write), .o_mem_data(o_mem_data), .o_alu_result(o_alu_result),
    .o_wb_addr(o_wb_addr), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: RAM as words, outputs as plain expected values.
  logic [31:0] mm [256];
  logic [31:0] e_mem_data = '0, e_alu = '0;
  logic [4:0]  e_wb = '0;
  logic        e_m2r = 1'b0, e_rw = 1'b0, e_mis = 1'b0;

  int          sz, sh, widx;
  bit          mis;
  logic [31:0] w, ld, v;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge i_clk) begin
    if (i_reset) begin
      e_mem_data = '0; e_alu = '0; e_wb = '0; e_m2r = 0; e_rw = 0; e_mis = 0;
    end else if (!i_halt) begin
      sz   = (i_width == 2'b00) ? 1 : (i_width == 2'b01) ? 2 : 4;
      mis  = (i_mem_rd || i_mem_wr) && ((i_alu_result % sz) != 0);
      widx = (i_alu_result / 4) % 256;
      w    = mm[widx];
      ld   = '0;
      if (i_mem_rd) begin
        if (sz == 4) ld = w;
        else if (sz == 2) begin
          v  = (w >> (16 * ((i_alu_result % 4) / 2))) & 32'hFFFF;
          ld = (i_sign_ext && v[15]) ? (v | 32'hFFFF0000) : v;
        end else begin
          v  = (w >> (8 * (i_alu_result % 4))) & 32'hFF;
          ld = (i_sign_ext && v[7]) ? (v | 32'hFFFFFF00) : v;
        end
      end
      if (i_mem_wr && !mis) begin
        if (sz == 4) mm[widx] = i_data_store;
        else if (sz == 2) begin
          sh = 16 * ((i_alu_result % 4) / 2);
          mm[widx] = (w & ~(32'hFFFF << sh)) | ((i_data_store & 32'hFFFF) << sh);
        end else begin
          sh = 8 * (i_alu_result % 4);
          mm[widx] = (w & ~(32'hFF << sh)) | ((i_data_store & 32'hFF) << sh);
        end
      end
      e_mem_data = ld; e_alu = i_alu_result; e_wb = i_wb_addr;
      e_m2r = i_mem_to_reg; e_rw = i_reg_write && !mis; e_mis = mis;
    end
    #1;
    if (chk_en) begin
      cmp("mem_data", o_mem_data, e_mem_data);
      cmp("alu_result", o_alu_result, e_alu);
      cmp("wb_addr", {27'd0, o_wb_addr}, {27'd0, e_wb});
      cmp("mem_to_reg", {31'd0, o_mem_to_reg}, {31'd0, e_m2r});
      cmp("reg_write", {31'd0, o_reg_write}, {31'd0, e_rw});
      cmp("misaligned", {31'd0, o_misaligned}, {31'd0, e_mis});
    end
  end

  task automatic drive(input logic rst, input logic halt, input logic rd, input logic wr,
                       input logic [1:0] wd, input logic sx, input logic [31:0] addr,
                       input logic [31:0] data, input logic rw);
    @(negedge i_clk);
    i_reset = rst; i_halt = halt; i_mem_rd = rd; i_mem_wr = wr; i_width = wd;
    i_sign_ext = sx; i_alu_result = addr; i_data_store = data;
    i_wb_addr = 5'($urandom); i_mem_to_reg = rd; i_reg_write = rw;
    @(posedge i_clk);
    #2;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    drive(0, 0, 0, 1, 2'b11, 0, a, d, 0);
  endtask

  task automatic lw(input logic [31:0] a);
    drive(0, 0, 1, 0, 2'b11, 0, a, $urandom, 1);
  endtask

  initial begin
    i_reset = 1; i_halt = 0; i_mem_rd = 0; i_mem_wr = 0; i_width = 0; i_sign_ext = 0;
    i_alu_result = 0; i_data_store = 0; i_wb_addr = 0; i_mem_to_reg = 0; i_reg_write = 0;
    @(posedge i_clk);
    #3 chk_en = 1'b1;

    for (int i = 0; i < 256; i++) sw(i * 4, $urandom);

    // Reset with garbage inputs (store + halt asserted) must clear outputs and not store.
    sw(32'h10, 32'h0BADF00D);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 1, 2'b11, 1, 32'h10, 32'hFFFFFFFF, 1);
      cmp("rst_mem_data", o_mem_data, 32'h0);
      cmp("rst_alu", o_alu_result, 32'h0);
      cmp("rst_rw", {31'd0, o_reg_write}, 32'h0);
    end
    lw(32'h10);
    cmp("rst_keeps_ram", o_mem_data, 32'h0BADF00D);

    sw(32'h20, 32'hDEADBEEF);
    lw(32'h20);
    cmp("lw_20", o_mem_data, 32'hDEADBEEF);
    cmp("lw_20_rw", {31'd0, o_reg_write}, 32'h1);
    cmp("lw_20_model", e_mem_data, 32'hDEADBEEF);

    sw(32'h40, 32'h80FF7F01);
    drive(0, 0, 1, 0, 2'b00, 1, 32'h43, 0, 1);
    cmp("lb_43", o_mem_data, 32'hFFFFFF80);
    cmp("lb_43_model", e_mem_data, 32'hFFFFFF80);
    drive(0, 0, 1, 0, 2'b00, 0, 32'h43, 0, 1);
    cmp("lbu_43", o_mem_data, 32'h00000080);
    drive(0, 0, 1, 0, 2'b01, 1, 32'h42, 0, 1);
    cmp("lh_42", o_mem_data, 32'hFFFF80FF);
    cmp("lh_42_model", e_mem_data, 32'hFFFF80FF);
    drive(0, 0, 1, 0, 2'b01, 0, 32'h40, 0, 1);
    cmp("lhu_40", o_mem_data, 32'h00007F01);

    sw(32'h60, 32'h11111111);
    drive(0, 0, 0, 1, 2'b00, 0, 32'h61, 32'h777777AB, 0);
    drive(0, 0, 0, 1, 2'b01, 0, 32'h62, 32'h1234CDEF, 0);
    lw(32'h60);
    cmp("partial_60", o_mem_data, 32'hCDEFAB11);
    cmp("partial_60_model", e_mem_data, 32'hCDEFAB11);

    sw(32'h80, 32'hA5A5A5A5);
    drive(0, 0, 0, 1, 2'b11, 0, 32'h81, 32'h12345678, 1);
    cmp("mis_sw_flag", {31'd0, o_misaligned}, 32'h1);
    cmp("mis_sw_rw", {31'd0, o_reg_write}, 32'h0);
    lw(32'h82);
    cmp("mis_lw_flag", {31'd0, o_misaligned}, 32'h1);
    cmp("mis_lw_rw", {31'd0, o_reg_write}, 32'h0);
    lw(32'h80);
    cmp("mis_no_write", o_mem_data, 32'hA5A5A5A5);
    cmp("mis_clear", {31'd0, o_misaligned}, 32'h0);

    // Halt: outputs frozen on the previous load, halted store must not land.
    sw(32'h0, 32'h01020304);
    lw(32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 2'b11, 0, 32'h400, 32'h55AA55AA, 0);
      cmp("halt_frozen_data", o_mem_data, 32'h01020304);
      cmp("halt_frozen_alu", o_alu_result, 32'h0);
    end
    lw(32'h0);
    cmp("halt_no_write", o_mem_data, 32'h01020304);
    sw(32'h400, 32'h55AA55AA);
    lw(32'h0);
    cmp("wrap_400", o_mem_data, 32'h55AA55AA);
    cmp("wrap_400_model", e_mem_data, 32'h55AA55AA);

    for (int n = 0; n < 3000; n++) begin
      int   r, k;
      logic rd, wr;
      logic [31:0] a;
      r  = $urandom_range(0, 99);
      k  = $urandom_range(0, 2);
      rd = (k == 0);
      wr = (k == 1);
      a  = $urandom_range(0, 1) ? $urandom : (($urandom & 32'hFFFFFC00) | $urandom_range(0, 63));
      drive(r < 2, (r >= 2) && (r < 12), rd, wr, 2'($urandom), 1'($urandom), a, $urandom,
            1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
